// File: rtl/s2mm_sched_pkg.sv
// s2mm_sched_pkg: shared types and helpers for the S2MM command scheduler.
//   - sched_state_e : scheduler FSM states
//   - command field offsets/widths of the 72-bit DataMover command word
//   - pack_s2mm_cmd : builds an INCR, EOF-terminated command word
package s2mm_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERROR = 3'd4
  } sched_state_e;

  localparam int unsigned CMD_W     = 72;
  localparam int unsigned BTT_LSB   = 0;
  localparam int unsigned BTT_W     = 23;
  localparam int unsigned TYPE_BIT  = 23;
  localparam int unsigned DSA_LSB   = 24;
  localparam int unsigned DSA_W     = 6;
  localparam int unsigned EOF_BIT   = 30;
  localparam int unsigned DRR_BIT   = 31;
  localparam int unsigned SADDR_LSB = 32;
  localparam int unsigned SADDR_W   = 32;
  localparam int unsigned TAG_LSB   = 64;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned RSVD_LSB  = 68;
  localparam int unsigned RSVD_W    = 4;

  // Assemble one write command: INCR burst, EOF set, no DRE realignment.
  function automatic logic [CMD_W-1:0] pack_s2mm_cmd(
    input logic [BTT_W-1:0]   btt,
    input logic [SADDR_W-1:0] saddr,
    input logic [TAG_W-1:0]   tag
  );
    logic [CMD_W-1:0] cmd;
    cmd                        = '0;
    cmd[BTT_LSB +: BTT_W]      = btt;
    cmd[TYPE_BIT]              = 1'b1;
    cmd[DSA_LSB +: DSA_W]      = '0;
    cmd[EOF_BIT]               = 1'b1;
    cmd[DRR_BIT]               = 1'b0;
    cmd[SADDR_LSB +: SADDR_W]  = saddr;
    cmd[TAG_LSB +: TAG_W]      = tag;
    cmd[RSVD_LSB +: RSVD_W]    = '0;
    return cmd;
  endfunction

endpackage

// File: rtl/s2mm_cmd_scheduler.sv
// s2mm_cmd_scheduler: issues DataMover S2MM commands into a circular capture
// buffer, keeping up to MAX_OUTSTANDING commands in flight, and publishes a
// completed-data write pointer and wrap count.
// Optional feature macro: S2MM_SCHED_ONESHOT_EN (stop issuing after one pass
// over the buffer; capture does not restart until acq_run is dropped).
// Ports:
//   axi_aclk, axi_aresetn       clock, synchronous active-low reset
//   acq_run, err_clr            acquisition control (level / pulse)
//   axis_cmd_t{data,valid,ready} DataMover command stream
//   s2mm_wr_xfer_cmplt          one pulse per completed command
//   s2mm_err, s2mm_halt         DataMover fault indications
//   write_ptr, wrap_count       completed-data position for the host
//   outstanding, busy, error    status
module s2mm_cmd_scheduler
  import s2mm_sched_pkg::*;
#(
  parameter logic [31:0] BUF_BASE        = 32'h0000_0000,
  parameter logic [31:0] BUF_SIZE        = 32'h1000_0000,
  parameter logic [31:0] XFER_BYTES      = 32'h0000_1000,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic        acq_run,
  input  logic        err_clr,
  output logic [71:0] axis_cmd_tdata,
  output logic        axis_cmd_tvalid,
  input  logic        axis_cmd_tready,
  input  logic        s2mm_wr_xfer_cmplt,
  input  logic        s2mm_err,
  input  logic        s2mm_halt,
  output logic [31:0] write_ptr,
  output logic [15:0] wrap_count,
  output logic [3:0]  outstanding,
  output logic        busy,
  output logic        error
);

  localparam logic [3:0]       MAX_OUT = 4'(MAX_OUTSTANDING);
  localparam logic [BTT_W-1:0] BTT     = BTT_W'(XFER_BYTES);

  sched_state_e state_q, state_d;
  logic [31:0]  issue_off_q, issue_off_d;
  logic [3:0]   tag_q, tag_d;
  logic [3:0]   outstanding_q, outstanding_d;
  logic [31:0]  write_ptr_q, write_ptr_d;
  logic [15:0]  wrap_count_q, wrap_count_d;
  logic         tvalid_q, tvalid_d;
  logic [71:0]  tdata_q, tdata_d;
  logic         error_q, error_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic         hs;
  logic         cmplt_eff;
  logic         off_wrap;
  logic [31:0]  off_next;
  logic         wp_wrap;
  logic [31:0]  wp_next;
  logic [3:0]   tag_next;

  // State and datapath registers.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q       <= ST_IDLE;
      issue_off_q   <= '0;
      tag_q         <= '0;
      outstanding_q <= '0;
      write_ptr_q   <= '0;
      wrap_count_q  <= '0;
      tvalid_q      <= 1'b0;
      tdata_q       <= '0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_off_q   <= issue_off_d;
      tag_q         <= tag_d;
      outstanding_q <= outstanding_d;
      write_ptr_q   <= write_ptr_d;
      wrap_count_q  <= wrap_count_d;
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Next-state, counters and command presentation.
  always_comb begin
    state_d       = state_q;
    issue_off_d   = issue_off_q;
    tag_d         = tag_q;
    outstanding_d = outstanding_q;
    write_ptr_d   = write_ptr_q;
    wrap_count_d  = wrap_count_q;
    tvalid_d      = tvalid_q;
    tdata_d       = tdata_q;
    error_d       = error_q;
    done_d        = done_q;

    hs        = tvalid_q & axis_cmd_tready;
    // Completions with nothing in flight (e.g. stragglers after reset) are dropped.
    cmplt_eff = s2mm_wr_xfer_cmplt & (outstanding_q != 4'd0);
    off_wrap  = (issue_off_q + XFER_BYTES) == BUF_SIZE;
    off_next  = off_wrap ? 32'd0 : issue_off_q + XFER_BYTES;
    wp_wrap   = (write_ptr_q + XFER_BYTES) == BUF_SIZE;
    wp_next   = wp_wrap ? 32'd0 : write_ptr_q + XFER_BYTES;
    tag_next  = tag_q + 4'd1;

    // Handshake and completion in one cycle cancel in the outstanding count.
    case ({hs, cmplt_eff})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase

    if (hs) begin
      issue_off_d = off_next;
      tag_d       = tag_next;
    end

    if (cmplt_eff) begin
      write_ptr_d = wp_next;
      if (wp_wrap && (wrap_count_q != 16'hFFFF)) begin
        wrap_count_d = wrap_count_q + 16'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        tvalid_d = 1'b0;
        if (!acq_run) begin
          done_d = 1'b0;
        end else if (!done_q) begin
          issue_off_d  = '0;
          write_ptr_d  = '0;
          wrap_count_d = '0;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (hs) begin
`ifdef S2MM_SCHED_ONESHOT_EN
          if (!acq_run || off_wrap) begin
            tvalid_d = 1'b0;
            state_d  = ST_DRAIN;
            done_d   = off_wrap;
          end else
`else
          if (!acq_run) begin
            tvalid_d = 1'b0;
            state_d  = ST_DRAIN;
          end else
`endif
          if (outstanding_d >= MAX_OUT) begin
            tvalid_d = 1'b0;
            state_d  = ST_WAIT;
          end else begin
            tdata_d = pack_s2mm_cmd(BTT, BUF_BASE + off_next, tag_next);
          end
        end else if (!tvalid_q) begin
          // First command after leaving IDLE.
          if (!acq_run) begin
            state_d = ST_DRAIN;
          end else if (outstanding_q < MAX_OUT) begin
            tvalid_d = 1'b1;
            tdata_d  = pack_s2mm_cmd(BTT, BUF_BASE + issue_off_q, tag_q);
          end else begin
            state_d = ST_WAIT;
          end
        end
        // tvalid_q && !tready: hold the presented command unchanged.
      end

      ST_WAIT: begin
        tvalid_d = 1'b0;
        if (!acq_run) begin
          state_d = ST_DRAIN;
        end else if (outstanding_d < MAX_OUT) begin
          state_d  = ST_ISSUE;
          tvalid_d = 1'b1;
          tdata_d  = pack_s2mm_cmd(BTT, BUF_BASE + issue_off_q, tag_q);
        end
      end

      ST_DRAIN: begin
        tvalid_d = 1'b0;
        if (outstanding_d == 4'd0) begin
          state_d = ST_IDLE;
        end
      end

      ST_ERROR: begin
        tvalid_d = 1'b0;
        if (err_clr && !acq_run) begin
          state_d       = ST_IDLE;
          error_d       = 1'b0;
          outstanding_d = '0;
        end
      end

      default: begin
        tvalid_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    // DataMover faults override every other transition.
    if ((s2mm_err || s2mm_halt) && (state_q != ST_IDLE)) begin
      state_d  = ST_ERROR;
      error_d  = 1'b1;
      tvalid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign axis_cmd_tdata  = tdata_q;
  assign axis_cmd_tvalid = tvalid_q;
  assign write_ptr       = write_ptr_q;
  assign wrap_count      = wrap_count_q;
  assign outstanding     = outstanding_q;
  assign busy            = busy_q;
  assign error           = error_q;

endmodule

// File: tb/tb_s2mm_cmd_scheduler.sv
// tb_s2mm_cmd_scheduler: scenario bench for s2mm_cmd_scheduler with
// BUF_SIZE=0x4000, XFER_BYTES=0x1000, MAX_OUTSTANDING=2. Expected commands
// are queued when a scenario starts capture and popped on each handshake.
// Build with S2MM_SCHED_ONESHOT_EN defined to exercise the one-shot variant.
module tb_s2mm_cmd_scheduler;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        acq_run;
  logic        err_clr;
  logic [71:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        cmplt;
  logic        s2mm_err;
  logic        s2mm_halt;
  logic [31:0] write_ptr;
  logic [15:0] wrap_count;
  logic [3:0]  outstanding;
  logic        busy;
  logic        error;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_hs     = 0;
  logic [71:0] sb[$];
  logic [31:0] m_off;
  logic [3:0]  m_tag;

  always #5 clk = ~clk;

  s2mm_cmd_scheduler #(
    .BUF_BASE       (32'h0000_0000),
    .BUF_SIZE       (32'h0000_4000),
    .XFER_BYTES     (32'h0000_1000),
    .MAX_OUTSTANDING(2)
  ) dut (
    .axi_aclk          (clk),
    .axi_aresetn       (aresetn),
    .acq_run           (acq_run),
    .err_clr           (err_clr),
    .axis_cmd_tdata    (tdata),
    .axis_cmd_tvalid   (tvalid),
    .axis_cmd_tready   (tready),
    .s2mm_wr_xfer_cmplt(cmplt),
    .s2mm_err          (s2mm_err),
    .s2mm_halt         (s2mm_halt),
    .write_ptr         (write_ptr),
    .wrap_count        (wrap_count),
    .outstanding       (outstanding),
    .busy              (busy),
    .error             (error)
  );

  function automatic logic [71:0] exp_cmd(input logic [31:0] off, input logic [3:0] tag);
    logic [71:0] c;
    c        = '0;
    c[22:0]  = 23'h1000;
    c[23]    = 1'b1;
    c[30]    = 1'b1;
    c[63:32] = off;
    c[67:64] = tag;
    return c;
  endfunction

  // Queue the next command the model expects the scheduler to issue.
  task automatic push_cmd();
    sb.push_back(exp_cmd(m_off, m_tag));
    m_off = (m_off == 32'h3000) ? 32'h0 : m_off + 32'h1000;
    m_tag = m_tag + 4'd1;
  endtask

  // Advance one cycle; a handshake about to happen is scored first.
  task automatic step();
    logic [71:0] e;
    if (tvalid && tready) begin
      n_hs++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_cmd: got tdata=%h, required no command", tdata);
      end else begin
        e = sb.pop_front();
        if (tdata !== e) begin
          n_fail++;
          $display("FAIL cmd_tdata: got %h, required %h", tdata, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tready    = 1'b0;
    acq_run   = 1'b0;
    err_clr   = 1'b0;
    cmplt     = 1'b0;
    s2mm_err  = 1'b0;
    s2mm_halt = 1'b0;
    aresetn   = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    aresetn = 1'b1;
    sb.delete();
    m_off = '0;
    m_tag = '0;
    n_hs  = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({tvalid, busy, error, outstanding} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_status: got tvalid/busy/error/outstanding=%b, required 0", {tvalid, busy, error, outstanding});
    end
    n_checks++;
    if (tdata !== 72'h0) begin n_fail++; $display("FAIL reset_tdata: got %h, required 0", tdata); end
    n_checks++;
    if ({write_ptr, wrap_count} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_ptrs: got write_ptr=%h wrap=%h, required 0", write_ptr, wrap_count);
    end
    // Reset mid-run, then a late completion must not underflow.
    acq_run = 1'b1;
    tready  = 1'b1;
    push_cmd();
    push_cmd();
    for (int c = 0; c < 5; c++) step();
    aresetn = 1'b0;
    tready  = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    acq_run = 1'b0;
    n_checks++;
    if ({tvalid, busy, outstanding, tdata} !== 78'h0) begin
      n_fail++;
      $display("FAIL midrun_reset: got tvalid=%b busy=%b outstanding=%0d tdata=%h, required all 0", tvalid, busy, outstanding, tdata);
    end
    cmplt = 1'b1;
    step();
    cmplt = 1'b0;
    n_checks++;
    if (outstanding !== 4'd0 || write_ptr !== 32'h0) begin
      n_fail++;
      $display("FAIL late_cmplt: got outstanding=%0d write_ptr=%h, required 0 and 0", outstanding, write_ptr);
    end
  endtask

  task automatic test_basic_issue();
    apply_reset();
    push_cmd();
    push_cmd();
    acq_run = 1'b1;
    tready  = 1'b1;
    step();
    n_checks++;
    if (tvalid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_n1: got tvalid=%b busy=%b, required 0 and 1", tvalid, busy);
    end
    step();
    n_checks++;
    if (tvalid !== 1'b1) begin n_fail++; $display("FAIL start_n2: got tvalid=%b, required 1", tvalid); end
    for (int c = 0; c < 8; c++) step();
    n_checks++;
    if (n_hs != 2 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL basic_count: got %0d handshakes, %0d pending, required 2 and 0", n_hs, sb.size());
    end
    n_checks++;
    if (tvalid !== 1'b0 || outstanding !== 4'd2) begin
      n_fail++;
      $display("FAIL basic_limit: got tvalid=%b outstanding=%0d, required 0 and 2", tvalid, outstanding);
    end
  endtask

  task automatic test_simultaneous();
    int c;
    apply_reset();
    push_cmd();
    push_cmd();
    acq_run = 1'b1;
    tready  = 1'b1;
    c = 0;
    while (n_hs < 1 && c < 10) begin step(); c++; end
    cmplt = 1'b1;
    step();
    cmplt  = 1'b0;
    tready = 1'b0;
    n_checks++;
    if (n_hs != 2) begin n_fail++; $display("FAIL simul_hs: got %0d handshakes, required 2", n_hs); end
    n_checks++;
    if (outstanding !== 4'd1 || write_ptr !== 32'h1000) begin
      n_fail++;
      $display("FAIL simul_update: got outstanding=%0d write_ptr=%h, required 1 and 1000", outstanding, write_ptr);
    end
  endtask

`ifndef S2MM_SCHED_ONESHOT_EN
  task automatic test_wrap();
    logic prev_hs;
    int   sent;
    apply_reset();
    for (int i = 0; i < 5; i++) push_cmd();
    acq_run = 1'b1;
    prev_hs = 1'b0;
    sent    = 0;
    for (int c = 0; c < 40; c++) begin
      tready = (n_hs < 5);
      cmplt  = prev_hs && (sent < 4);
      if (cmplt) sent++;
      prev_hs = tvalid && tready;
      step();
    end
    cmplt = 1'b0;
    n_checks++;
    if (n_hs != 5 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_count_cmds: got %0d handshakes, %0d pending, required 5 and 0", n_hs, sb.size());
    end
    n_checks++;
    if (write_ptr !== 32'h0 || wrap_count !== 16'd1) begin
      n_fail++;
      $display("FAIL wrap_ptrs: got write_ptr=%h wrap_count=%0d, required 0 and 1", write_ptr, wrap_count);
    end
    n_checks++;
    if (outstanding !== 4'd1) begin n_fail++; $display("FAIL wrap_outstanding: got %0d, required 1", outstanding); end
  endtask
`else
  task automatic test_oneshot();
    logic prev_hs;
    apply_reset();
    for (int i = 0; i < 4; i++) push_cmd();
    acq_run = 1'b1;
    tready  = 1'b1;
    prev_hs = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cmplt   = prev_hs;
      prev_hs = tvalid && tready;
      step();
    end
    cmplt = 1'b0;
    n_checks++;
    if (n_hs != 4 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL oneshot_cmds: got %0d handshakes, %0d pending, required 4 and 0", n_hs, sb.size());
    end
    n_checks++;
    if (wrap_count !== 16'd1 || busy !== 1'b0 || write_ptr !== 32'h0) begin
      n_fail++;
      $display("FAIL oneshot_end: got wrap=%0d busy=%b write_ptr=%h, required 1, 0, 0", wrap_count, busy, write_ptr);
    end
  endtask
`endif

  task automatic test_stop();
    int c;
    apply_reset();
    push_cmd();
    acq_run = 1'b1;
    c = 0;
    while (!tvalid && c < 10) begin step(); c++; end
    n_checks++;
    if (tvalid !== 1'b1) begin n_fail++; $display("FAIL stop_wait_valid: got tvalid=%b, required 1", tvalid); end
    acq_run = 1'b0;
    for (int k = 0; k < 3; k++) step();
    n_checks++;
    if (tvalid !== 1'b1 || tdata !== exp_cmd(32'h0, 4'd0)) begin
      n_fail++;
      $display("FAIL stop_hold: got tvalid=%b tdata=%h, required 1 and %h", tvalid, tdata, exp_cmd(32'h0, 4'd0));
    end
    tready = 1'b1;
    step();
    tready = 1'b0;
    n_checks++;
    if (n_hs != 1 || tvalid !== 1'b0 || busy !== 1'b1 || outstanding !== 4'd1) begin
      n_fail++;
      $display("FAIL stop_drain: got hs=%0d tvalid=%b busy=%b outstanding=%0d, required 1,0,1,1", n_hs, tvalid, busy, outstanding);
    end
    step();
    cmplt = 1'b1;
    step();
    cmplt = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || outstanding !== 4'd0 || write_ptr !== 32'h1000) begin
      n_fail++;
      $display("FAIL stop_idle: got busy=%b outstanding=%0d write_ptr=%h, required 0, 0, 1000", busy, outstanding, write_ptr);
    end
  endtask

  task automatic test_error();
    int c;
    apply_reset();
    acq_run = 1'b1;
    c = 0;
    while (!tvalid && c < 10) begin step(); c++; end
    s2mm_err = 1'b1;
    step();
    s2mm_err = 1'b0;
    n_checks++;
    if (error !== 1'b1 || tvalid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got error=%b tvalid=%b busy=%b, required 1, 0, 1", error, tvalid, busy);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_checks++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL err_clr_running: got error=%b, required 1", error); end
    acq_run = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b0 || outstanding !== 4'd0) begin
      n_fail++;
      $display("FAIL err_cleared: got error=%b busy=%b outstanding=%0d, required 0, 0, 0", error, busy, outstanding);
    end
    // Restart after recovery issues from the buffer start.
    push_cmd();
    acq_run = 1'b1;
    tready  = 1'b1;
    c = 0;
    while (n_hs < 1 && c < 10) begin step(); c++; end
    tready = 1'b0;
    n_checks++;
    if (n_hs != 1) begin n_fail++; $display("FAIL err_restart: got %0d handshakes, required 1", n_hs); end
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_simultaneous();
`ifndef S2MM_SCHED_ONESHOT_EN
    test_wrap();
`else
    test_oneshot();
`endif
    test_stop();
    test_error();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
